hazard_forward_unit: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipelined RV32I core.
- Sits directly upstream of the EX-stage operand selectors (Mux_3_by_1 instances). It generates their 2-bit select inputs: 00 = register-file operand, 01 = writeback result, 10 = MEM-stage ALU result.
- Keeps its own shadow pipeline of register-usage fields (EX/MEM/WB). It also drives the stall/flush controls for the IF/ID/EX pipeline registers and counts stall cycles.

---
 rtl/hazard_forward_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard detection and operand-forwarding controller for the 5-stage RV32I
// pipeline. It keeps a private shadow copy of the register-usage fields for
// the EX, MEM and WB stages. From that copy it produces:
//   - the 2-bit selects for the EX-stage operand muxes:
//       00 = register file, 01 = writeback result, 10 = MEM-stage ALU result
//   - the stall/flush controls for the IF/ID and ID/EX pipeline registers
//   - a saturating count of load-use stall cycles
//
// Ports:
//   clk          core clock
//   rst          asynchronous reset, active-low
//   rs1_d/rs2_d  source registers of the instruction currently in ID
//   rd_d         destination register of the instruction in ID
//   regwrite_d   ID instruction writes rd
//   load_d       ID instruction is a load
//   pcsrc_e      branch taken / jump resolved in EX
//   forward_a_e  operand-A mux select
//   forward_b_e  operand-B mux select
//   stall_f      hold PC
//   stall_d      hold IF/ID register
//   flush_d      clear IF/ID register
//   flush_e      clear ID/EX register
//   stall_count  load-use stall cycles since reset (saturating)
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  regwrite_d,
    input  logic                  load_d,
    input  logic                  pcsrc_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0]      FWD_RF  = 2'b00;
    localparam logic [1:0]      FWD_WB  = 2'b01;
    localparam logic [1:0]      FWD_MEM = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Shadow pipeline state
    logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
    logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
    logic [REG_ADDR_W-1:0] rd_e_q,  rd_e_d;
    logic                  regwrite_e_q, regwrite_e_d;
    logic                  load_e_q, load_e_d;
    logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d;
    logic                  regwrite_m_q, regwrite_m_d;
    logic [REG_ADDR_W-1:0] rd_w_q, rd_w_d;
    logic                  regwrite_w_q, regwrite_w_d;
    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic lwstall;

    // MEM has priority over WB because it holds the younger value. x0 never
    // forwards. A load sitting in MEM cannot meet a dependent consumer here,
    // because the load-use stall always puts a bubble between them.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rw_m,
        input logic [REG_ADDR_W-1:0] rdm,
        input logic                  rw_w,
        input logic [REG_ADDR_W-1:0] rdw
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != '0 && rw_m && rdm == rs) begin
            sel = FWD_MEM;
        end else if (rs != '0 && rw_w && rdw == rs) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Hazard and control outputs. The branch flush is masked while reset is
    // held so that every control output reads zero during reset. The shadow
    // state is already zero in reset, so lwstall needs no extra masking.
    // When a branch and a load-use stall occur together, all four controls
    // are asserted and the PC mux gives the branch target priority.
    always_comb begin
        lwstall = load_e_q && (rd_e_q != '0) &&
                  ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));
        stall_f = lwstall;
        stall_d = lwstall;
        flush_d = pcsrc_e && rst;
        flush_e = lwstall || flush_d;

        forward_a_e = fwd_sel(rs1_e_q, regwrite_m_q, rd_m_q, regwrite_w_q, rd_w_q);
        forward_b_e = fwd_sel(rs2_e_q, regwrite_m_q, rd_m_q, regwrite_w_q, rd_w_q);

        stall_count = stall_count_q;
    end

    // Next-state logic. The shadow pipeline never stalls. On a flush, EX
    // takes an all-zero bubble while the real ID instruction is held
    // upstream and shown to us again on the next cycle.
    always_comb begin
        rs1_e_d      = rs1_d;
        rs2_e_d      = rs2_d;
        rd_e_d       = rd_d;
        regwrite_e_d = regwrite_d;
        load_e_d     = load_d;
        if (flush_e) begin
            rs1_e_d      = '0;
            rs2_e_d      = '0;
            rd_e_d       = '0;
            regwrite_e_d = 1'b0;
            load_e_d     = 1'b0;
        end

        rd_m_d       = rd_e_q;
        regwrite_m_d = regwrite_e_q;
        rd_w_d       = rd_m_q;
        regwrite_w_d = regwrite_m_q;

        // Saturate rather than wrap so that a long run never reads as a short one
        stall_count_d = stall_count_q;
        if (lwstall && stall_count_q != CNT_MAX) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers. An asynchronous clear leaves an empty pipeline behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            rd_e_q        <= '0;
            regwrite_e_q  <= 1'b0;
            load_e_q      <= 1'b0;
            rd_m_q        <= '0;
            regwrite_m_q  <= 1'b0;
            rd_w_q        <= '0;
            regwrite_w_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            regwrite_e_q  <= regwrite_e_d;
            load_e_q      <= load_e_d;
            rd_m_q        <= rd_m_d;
            regwrite_m_q  <= regwrite_m_d;
            rd_w_q        <= rd_w_d;
            regwrite_w_q  <= regwrite_w_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed testbench for hazard_forward_unit. Every expected value is worked
// out by hand from the instruction sequence driven into ID. A second instance
// uses a 2-bit stall counter so that saturation is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       regwrite_d, load_d, pcsrc_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [15:0] stall_count;

    logic [1:0] sat_forward_a_e, sat_forward_b_e;
    logic       sat_stall_f, sat_stall_d, sat_flush_d, sat_flush_e;
    logic [1:0] sat_stall_count;

    int numCompared;
    int numMismatched;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e),
        .stall_count(stall_count)
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
        .forward_a_e(sat_forward_a_e), .forward_b_e(sat_forward_b_e),
        .stall_f(sat_stall_f), .stall_d(sat_stall_d),
        .flush_d(sat_flush_d), .flush_e(sat_flush_e),
        .stall_count(sat_stall_count)
    );

    // Free-running clock with its rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present one instruction in ID, then let the combinational outputs settle
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rw,
                                 input logic ld, input logic pc);
        rs1_d      = rs1;
        rs2_d      = rs2;
        rd_d       = rd;
        regwrite_d = rw;
        load_d     = ld;
        pcsrc_e    = pc;
        #1;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            nextCycle();
        end
    endtask

    // Compare all six control outputs against one expected set
    task automatic checkControls(input string tag, input logic [1:0] fa,
                                 input logic [1:0] fb, input logic sf,
                                 input logic fd, input logic fe);
        checkOutput({tag, ".fwd_a"},   32'(forward_a_e), 32'(fa));
        checkOutput({tag, ".fwd_b"},   32'(forward_b_e), 32'(fb));
        checkOutput({tag, ".stall_f"}, 32'(stall_f),     32'(sf));
        checkOutput({tag, ".stall_d"}, 32'(stall_d),     32'(sf));
        checkOutput({tag, ".flush_d"}, 32'(flush_d),     32'(fd));
        checkOutput({tag, ".flush_e"}, 32'(flush_e),     32'(fe));
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst = 1'b0;

        // During reset, a taken branch must not leak through to the flushes
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #3;
        checkControls("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.count", 32'(stall_count), 32'd0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Idle pipeline
        idleCycles(5);
        checkControls("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("idle.count", 32'(stall_count), 32'd0);

        // ALU chain: writer x5, reader rs1=x5, reader rs2=x5
        applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("alu.prod_in_ex", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("alu.mem_fwd_a", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("alu.wb_fwd_b", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // Back-to-back writer x6 then reader rs2=x6 forwards from MEM
        applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("alu.mem_fwd_b", 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // Load-use: load x7, then reader rs2=x7 held in ID for the stall
        applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("ldu.stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("ldu.count_before", 32'(stall_count), 32'd0);
        nextCycle();
        applyStimulus(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("ldu.bubble", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("ldu.count_after", 32'(stall_count), 32'd1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("ldu.wb_fwd_b", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // Two writers of x3, then a reader: MEM must win over WB
        applyStimulus(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("dbl.mem_prio", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // x0 is never forwarded
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkControls("x0.no_fwd", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        // A load of x0 never stalls
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("x0.no_stall", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("x0.count", 32'(stall_count), 32'd1);
        idleCycles(3);

        // Branch flush: writer x4, then reader rs1=x4 killed by pcsrc_e
        applyStimulus(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkControls("br.flush", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkControls("br.bubble", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // Branch and load-use in the same cycle: everything asserts
        applyStimulus(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkControls("brld.both", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
        nextCycle();
        checkOutput("brld.count", 32'(stall_count), 32'd2);
        idleCycles(3);

        // A self-dependent load (rs1=rd=x7) held in ID stalls every other
        // cycle: 8 edges give 4 more stalls, so 6 in total. The 2-bit counter
        // must stop at 3; a wrapping one would read 2.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("sat.count_main", 32'(stall_count), 32'd6);
        checkOutput("sat.count_2bit", 32'(sat_stall_count), 32'd3);
        idleCycles(3);

        // Mid-operation reset: set up an active forward plus a branch, then
        // drop reset away from any clock edge
        applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkControls("mid.pre", 2'b10, 2'b00, 1'b0, 1'b1, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        checkControls("mid.reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("mid.count", 32'(stall_count), 32'd0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        nextCycle();
        checkControls("mid.after", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("mid.count_after", 32'(stall_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
